// File: rtl/data_memory_ctrl.sv
// Data-memory controller: latches one load/store request, inserts WAIT_CYCLES
// wait states, then performs a single little-endian byte/half/word RAM access.
module data_memory_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [2:0]            size,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  fault,
    output logic                  stall
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DEPTH   = (2 ** ADDR_WIDTH) / 4;
    localparam int unsigned WAIT_LD = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q;
    logic [2:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    done_q;
    logic                    fault_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    illegal_c;
    logic                    access_c;
    logic                    acc_we_c;
    logic [2:0]              acc_size_c;
    logic [ADDR_WIDTH-1:0]   acc_addr_c;
    logic [DATA_WIDTH-1:0]   acc_wdata_c;
    logic [31:0]             rword_c;
    logic [7:0]              byte_c;
    logic [15:0]             half_c;
    logic [31:0]             load_c;
    logic [3:0]              be_c;
    logic [31:0]             wrep_c;
    logic                    unused_c;

    // Upper address bits are deliberately dropped so addresses wrap.
    assign unused_c = ^addr[DATA_WIDTH-1:ADDR_WIDTH];

    // Legality of the request currently presented on the inputs.
    always_comb begin
        illegal_c = 1'b0;
        if (size == 3'b011 || size == 3'b110 || size == 3'b111) illegal_c = 1'b1;
        if (we && size[2])                                      illegal_c = 1'b1;
        if (size[1:0] == 2'b01 && addr[0])                      illegal_c = 1'b1;
        if (size[1:0] == 2'b10 && addr[1:0] != 2'b00)           illegal_c = 1'b1;
    end

    // Zero-wait accesses happen straight from IDLE, so take live inputs there.
    always_comb begin
        acc_we_c    = (state_q == IDLE) ? we    : we_q;
        acc_size_c  = (state_q == IDLE) ? size  : size_q;
        acc_addr_c  = (state_q == IDLE) ? addr[ADDR_WIDTH-1:0] : addr_q;
        acc_wdata_c = (state_q == IDLE) ? wdata : wdata_q;
    end

    // Next-state, wait counter, RAM access strobe and stall.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        access_c = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    if (illegal_c) begin
                        state_d = ERR;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d  = DONE;
                        access_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_LD);
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    access_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load-data selection and extension from the addressed word.
    always_comb begin
        rword_c = mem_q[acc_addr_c[ADDR_WIDTH-1:2]];
        byte_c  = rword_c[{acc_addr_c[1:0], 3'b000} +: 8];
        half_c  = acc_addr_c[1] ? rword_c[31:16] : rword_c[15:0];
        case (acc_size_c)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b100:  load_c = {24'd0, byte_c};
            3'b101:  load_c = {16'd0, half_c};
            default: load_c = rword_c;
        endcase
    end

    // Store byte enables and lane-replicated store data.
    always_comb begin
        case (acc_size_c[1:0])
            2'b00: begin
                be_c   = 4'b0001 << acc_addr_c[1:0];
                wrep_c = {4{acc_wdata_c[7:0]}};
            end
            2'b01: begin
                be_c   = acc_addr_c[1] ? 4'b1100 : 4'b0011;
                wrep_c = {2{acc_wdata_c[15:0]}};
            end
            default: begin
                be_c   = 4'b1111;
                wrep_c = acc_wdata_c[31:0];
            end
        endcase
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && access_c && acc_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) mem_q[acc_addr_c[ADDR_WIDTH-1:2]][8*i +: 8] <= wrep_c[8*i +: 8];
            end
        end
    end

    // Control state, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                addr_q  <= addr[ADDR_WIDTH-1:0];
                wdata_q <= wdata;
            end
            done_q  <= (state_d == DONE) || (state_d == ERR);
            fault_q <= (state_d == ERR);
            if (access_c && !acc_we_c) rdata_q <= load_c;
        end
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a transaction-level model (byte-array RAM plus
// done countdown) checked every cycle, and directed literal expectations.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_v;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_v [2];
    logic [1:0]  done_v, fault_v, stall_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: two wait states.  Instance 1: zero wait states.
    data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[0]), .done(done_v[0]), .fault(fault_v[0]),
        .stall(stall_v[0])
    );
    data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[1]), .done(done_v[1]), .fault(fault_v[1]),
        .stall(stall_v[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mm [2][4096];
    bit          mk [2][4096];
    int          left [2];
    bit          m_done [2], m_fault [2], m_rk [2];
    logic [31:0] m_rdata [2];
    bit          m_live = 1'b0;
    bit          p_we [2];
    logic [2:0]  p_size [2];
    logic [31:0] p_addr [2], p_wdata [2];

    function automatic bit is_illegal(input bit w, input logic [2:0] s, input logic [31:0] a);
        if (s == 3'd3 || s == 3'd6 || s == 3'd7) return 1'b1;
        if (w && s[2]) return 1'b1;
        if (s[1:0] == 2'd1 && a[0]) return 1'b1;
        if (s[1:0] == 2'd2 && a[1:0] != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void apply(input int d);
        int          a;
        int          n;
        logic [31:0] v;
        bit          known;
        a = int'(p_addr[d] % 32'd4096);
        n = 1 << p_size[d][1:0];
        if (p_we[d]) begin
            for (int i = 0; i < n; i++) begin
                mm[d][a + i] = p_wdata[d][8*i +: 8];
                mk[d][a + i] = 1'b1;
            end
        end else begin
            v = 32'd0;
            known = 1'b1;
            for (int i = 0; i < n; i++) begin
                v[8*i +: 8] = mm[d][a + i];
                known = known & mk[d][a + i];
            end
            if (!p_size[d][2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!p_size[d][2] && n == 2) v = {{16{v[15]}}, v[15:0]};
            m_rdata[d] = v;
            m_rk[d]    = known;
        end
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_rk[d] = 1'b0;
            left[d] = 0;
            for (int i = 0; i < 4096; i++) mk[d][i] = 1'b0;
        end
    end

    // Advance the model one clock: accept, count down, complete.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int waits;
            bit prev;
            waits = (d == 0) ? 2 : 0;
            if (rst) begin
                left[d] = 0; m_done[d] = 1'b0; m_fault[d] = 1'b0;
                m_rdata[d] = 32'd0; m_rk[d] = 1'b1;
            end else begin
                prev = m_done[d];
                m_done[d] = 1'b0;
                m_fault[d] = 1'b0;
                if (left[d] > 0) begin
                    left[d]--;
                    if (left[d] == 0) begin
                        apply(d);
                        m_done[d] = 1'b1;
                    end
                end else if (!prev && req_v[d]) begin
                    p_we[d] = we; p_size[d] = size; p_addr[d] = addr; p_wdata[d] = wdata;
                    if (is_illegal(we, size, addr)) begin
                        m_done[d] = 1'b1;
                        m_fault[d] = 1'b1;
                    end else if (waits == 0) begin
                        apply(d);
                        m_done[d] = 1'b1;
                    end else begin
                        left[d] = waits;
                    end
                end
            end
        end
        if (rst) m_live = 1'b1;
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (m_live) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("done[%0d]", d), {31'd0, done_v[d]}, {31'd0, m_done[d]});
                chk($sformatf("stall[%0d]", d), {31'd0, stall_v[d]},
                    {31'd0, (left[d] > 0) || (!m_done[d] && req_v[d])});
                if (m_done[d]) chk($sformatf("fault[%0d]", d), {31'd0, fault_v[d]}, {31'd0, m_fault[d]});
                if (m_rk[d]) chk($sformatf("rdata[%0d]", d), rdata_v[d], m_rdata[d]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic access(input int d, input bit w, input logic [2:0] s, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output int nst, output bit flt);
        we = w; size = s; addr = a; wdata = wd; req_v[d] = 1'b1;
        lat = 0; nst = 0; flt = 1'b0;
        #1;
        if (stall_v[d]) nst++;
        @(posedge clk); #2;
        req_v[d] = 1'b0;
        we = 1'($urandom); size = 3'($urandom); addr = $urandom; wdata = $urandom;
        lat = 1;
        while (!done_v[d] && lat < 20) begin
            if (stall_v[d]) nst++;
            @(posedge clk); #2;
            lat++;
        end
        if (!done_v[d]) begin
            checks++; errors++;
            $display("FAIL timeout: no done for dut %0d addr %h", d, a);
        end
        flt = fault_v[d];
        @(posedge clk); #2;
    endtask

    initial begin
        int lat, nst, cnt_d, cnt_s;
        bit flt;
        rst = 1'b1; req_v = 2'b00; we = 1'b0; size = 3'd0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset rdata", rdata_v[0], 32'h0);
        chk("reset done", {31'd0, done_v[0]}, 32'd0);

        access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, nst, flt);
        chk("SW latency", lat, 3);
        chk("SW stall cycles", nst, 3);
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, lat, nst, flt);
        chk("LW latency", lat, 3);
        chk("LW stall cycles", nst, 3);
        chk("LW 0x10", rdata_v[0], 32'hDEADBEEF);

        access(0, 1'b1, 3'b010, 32'h20, 32'h44332211, lat, nst, flt);
        access(0, 1'b1, 3'b000, 32'h21, 32'hABCDEF80, lat, nst, flt);
        access(0, 1'b0, 3'b000, 32'h21, 32'h0, lat, nst, flt);
        chk("LB 0x21", rdata_v[0], 32'hFFFFFF80);
        access(0, 1'b0, 3'b100, 32'h21, 32'h0, lat, nst, flt);
        chk("LBU 0x21", rdata_v[0], 32'h00000080);
        access(0, 1'b0, 3'b010, 32'h20, 32'h0, lat, nst, flt);
        chk("LW 0x20 after SB", rdata_v[0], 32'h44338011);
        access(0, 1'b1, 3'b001, 32'h22, 32'h12348001, lat, nst, flt);
        access(0, 1'b0, 3'b001, 32'h22, 32'h0, lat, nst, flt);
        chk("LH 0x22", rdata_v[0], 32'hFFFF8001);
        access(0, 1'b0, 3'b101, 32'h22, 32'h0, lat, nst, flt);
        chk("LHU 0x22", rdata_v[0], 32'h00008001);

        access(0, 1'b0, 3'b010, 32'h22, 32'h0, lat, nst, flt);
        chk("LW misaligned latency", lat, 1);
        chk("LW misaligned fault", {31'd0, flt}, 32'd1);
        chk("LW misaligned rdata hold", rdata_v[0], 32'h00008001);
        access(0, 1'b1, 3'b001, 32'h23, 32'h0000FFFF, lat, nst, flt);
        chk("SH misaligned fault", {31'd0, flt}, 32'd1);
        chk("SH misaligned latency", lat, 1);
        access(0, 1'b0, 3'b011, 32'h20, 32'h0, lat, nst, flt);
        chk("size 011 fault", {31'd0, flt}, 32'd1);
        access(0, 1'b1, 3'b100, 32'h20, 32'h000000FF, lat, nst, flt);
        chk("store size100 fault", {31'd0, flt}, 32'd1);
        access(0, 1'b0, 3'b010, 32'h20, 32'h0, lat, nst, flt);
        chk("RAM unchanged after faults", rdata_v[0], 32'h80018011);
        chk("legal LW no fault", {31'd0, flt}, 32'd0);

        access(0, 1'b1, 3'b010, 32'h1004, 32'h12345678, lat, nst, flt);
        access(0, 1'b0, 3'b010, 32'h004, 32'h0, lat, nst, flt);
        chk("LW wrap 0x004", rdata_v[0], 32'h12345678);

        // Store aborted by reset in its second wait cycle.
        access(0, 1'b1, 3'b010, 32'h30, 32'hAAAAAAAA, lat, nst, flt);
        cnt_d = 0;
        we = 1'b1; size = 3'b010; addr = 32'h30; wdata = 32'h55555555; req_v[0] = 1'b1;
        @(posedge clk); #2 req_v[0] = 1'b0;
        if (done_v[0]) cnt_d++;
        @(posedge clk); #2 rst = 1'b1;
        if (done_v[0]) cnt_d++;
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_v[0]) cnt_d++;
            @(posedge clk); #2;
        end
        chk("aborted store done count", cnt_d, 0);
        chk("rdata after abort reset", rdata_v[0], 32'h0);
        access(0, 1'b0, 3'b010, 32'h30, 32'h0, lat, nst, flt);
        chk("LW 0x30 after abort", rdata_v[0], 32'hAAAAAAAA);

        // Zero-wait instance, back-to-back loads with req held high.
        access(1, 1'b1, 3'b010, 32'h40, 32'h0BADF00D, lat, nst, flt);
        chk("W0 SW latency", lat, 1);
        chk("W0 SW stall cycles", nst, 1);
        cnt_d = 0; cnt_s = 0;
        we = 1'b0; size = 3'b010; addr = 32'h40; req_v[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (done_v[1]) cnt_d++;
            if (stall_v[1]) cnt_s++;
            @(posedge clk); #2;
        end
        req_v[1] = 1'b0;
        chk("W0 back-to-back dones", cnt_d, 4);
        chk("W0 back-to-back stalls", cnt_s, 4);
        chk("W0 LW 0x40", rdata_v[1], 32'h0BADF00D);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data and address width; the block supports only 32.
REQ-002 Parameter ADDR_WIDTH, default 12: byte-address bits used internally, giving 2^ADDR_WIDTH bytes of RAM.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states inserted before each access; legal range 0..15.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  1  access request from the execute stage.
REQ-007 we  input  1  1 = store, 0 = load; sampled with req.
REQ-008 size  input  3  funct3 access-size code; sampled with req.
REQ-009 addr  input  DATA_WIDTH  byte address (the ALU result); sampled with req.
REQ-010 wdata  input  DATA_WIDTH  store data; sampled with req.
REQ-011 rdata  output  DATA_WIDTH  load result, registered.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 fault  output  1  misaligned or illegal access; valid only with done.
REQ-014 stall  output  1  pipeline hold request to upstream stages.

Function
REQ-015 The block SHALL implement the FSM states IDLE, WAIT, DONE and ERR.
REQ-016 In IDLE with req=1, the block SHALL latch we, size, addr and wdata, then check the access.
REQ-017 After the IDLE check, the block SHALL go to ERR if the access is illegal, else to WAIT, or to DONE when WAIT_CYCLES=0.
REQ-018 An access SHALL be illegal for:
  - size 011, 110 or 111;
  - a store with size[2]=1;
  - a halfword with addr[0]=1;
  - a word with addr[1:0]!=00.
REQ-019 WAIT SHALL load a down-counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and go to DONE when it reads 0.
REQ-020 The RAM access SHALL occur only on the WAIT->DONE edge, or the IDLE->DONE edge when WAIT_CYCLES=0.
REQ-021 For a request accepted in cycle T, done SHALL be 1 in cycle T+WAIT_CYCLES+1.
REQ-022 DONE and ERR SHALL each last exactly one cycle, assert done=1, and return to IDLE.
REQ-023 ERR SHALL also assert fault=1, perform no RAM write, and leave rdata unchanged.
REQ-024 The block SHALL evaluate stall combinationally as 1 when (IDLE and req) or WAIT, and 0 in DONE and ERR.
REQ-025 req SHALL be ignored in WAIT, DONE and ERR, so a new request is accepted no earlier than the cycle after done.
REQ-026 Addressing:
  - only addr[ADDR_WIDTH-1:0] SHALL be used;
  - upper bits are ignored, so addresses wrap modulo 2^ADDR_WIDTH;
  - byte order is little-endian.
REQ-027 Loads: size 000 (LB) and 001 (LH) SHALL sign-extend, 100 (LBU) and 101 (LHU) SHALL zero-extend, and 010 (LW) SHALL return the full word.
REQ-028 Stores: size 000 (SB) SHALL write byte wdata[7:0], 001 (SH) halfword wdata[15:0], and 010 (SW) the full word; untouched bytes SHALL be preserved.
REQ-029 rdata SHALL update only on a successful load's DONE cycle and hold its value otherwise; stores SHALL not change rdata.
REQ-030 Changes on the inputs after acceptance SHALL have no effect on the access in progress.

Reset
REQ-031 With rst=1 at a clock edge, the FSM SHALL go to IDLE, the counter to 0, rdata to 0, and done and fault to 0.
REQ-032 rst SHALL override req in the same cycle.
REQ-033 rst during WAIT SHALL abort the access with no RAM write and no done pulse.
REQ-034 RAM contents SHALL not be cleared by reset.

Verification
REQ-035 SW then LW at addr 0x10 with wdata 0xDEADBEEF, WAIT_CYCLES=2 -> done pulses 3 cycles after each accept, stall=1 for 3 cycles per access, rdata=0xDEADBEEF.
REQ-036 Sign/zero extension:
  - setup: SB 0x80 to addr 0x21;
  - LB 0x21 -> rdata=0xFFFFFF80;
  - LBU 0x21 -> rdata=0x00000080;
  - LW 0x20 -> byte 1 = 0x80, other bytes unchanged.
REQ-037 Faults:
  - LW at 0x22 -> ERR: done=1 and fault=1 one cycle after accept, RAM unchanged, rdata unchanged;
  - SH at 0x23 -> same response;
  - size 011 -> same response.
REQ-038 SW 0x12345678 to 0x1004 with ADDR_WIDTH=12, then LW 0x004 -> rdata=0x12345678 (wrap).
REQ-039 SW 0xAAAAAAAA to 0x30, then SW 0x55555555 to 0x30 with rst pulsed in its 2nd WAIT cycle, then LW 0x30 -> no done for the aborted store, rdata=0xAAAAAAAA.
REQ-040 WAIT_CYCLES=0, req held high for back-to-back LWs -> done on alternate cycles, stall=1 only in the IDLE cycles with req=1.
